// File: rtl/aes_bram_port_ctrl.sv
// -----------------------------------------------------------------------------
// aes_bram_port_ctrl
//
// Bridges the AES control FSM's level-sensitive word requests onto the native
// single-port interface of the BRAM's Port B (Port A belongs to the AXI side).
// A request is held high by the requester until it sees bram_complete; the
// controller issues exactly one BRAM cycle per accepted request, waits out the
// configured read latency, and answers with a one-cycle bram_complete pulse.
//
// Parameters
//   READ_LATENCY : cycles from the bram_en read cycle to valid bram_dout (1..4)
//   ADDR_WIDTH   : width of the BRAM byte address (at most 32)
//
// Ports
//   aes_clk, aes_rst_n       : clock (rising edge) and async active-low reset
//   aes_start_read/_write    : request levels; read wins when both are high
//   aes_bram_addr            : byte address for reads
//   aes_bram_write_addr/data : byte address and data for writes
//   aes_bram_read_data       : last read word, updated when a read completes
//   bram_complete, bram_err  : completion pulse, error flag for misaligned addr
//   bram_addr/en/we/din/dout : native BRAM Port B signals
//   rd_count, wr_count       : wrapping counts of successful reads / writes
//
// Timing seen by the requester (edges counted from the edge that samples the
// start level in IDLE to the edge that samples bram_complete=1):
//   write 3, read 3+READ_LATENCY, misaligned 2.
// -----------------------------------------------------------------------------
module aes_bram_port_ctrl #(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  aes_clk,
  input  logic                  aes_rst_n,
  input  logic                  aes_start_read,
  input  logic                  aes_start_write,
  input  logic [31:0]           aes_bram_addr,
  input  logic [31:0]           aes_bram_write_addr,
  input  logic [31:0]           aes_bram_write_data,
  output logic [31:0]           aes_bram_read_data,
  output logic                  bram_complete,
  output logic                  bram_err,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [31:0]           bram_din,
  input  logic [31:0]           bram_dout,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY);

  // Word alignment check on a captured byte address.
  function automatic logic is_misaligned(input logic [31:0] addr);
    is_misaligned = (addr[1:0] != 2'b00);
  endfunction

  state_t                r_state;
  logic                  r_is_read;
  logic                  r_err;
  logic [2:0]            r_lat_cnt;
  logic [31:0]           r_rdata;
  logic                  r_complete;
  logic                  r_err_out;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic                  r_bram_en;
  logic [3:0]            r_bram_we;
  logic [31:0]           r_bram_din;
  logic [15:0]           r_rd_count;
  logic [15:0]           r_wr_count;

  logic                  w_rd_misaligned;
  logic                  w_wr_misaligned;

  assign w_rd_misaligned = is_misaligned(aes_bram_addr);
  assign w_wr_misaligned = is_misaligned(aes_bram_write_addr);

  // Request FSM; every output is a register written alongside the state.
  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      r_state     <= ST_IDLE;
      r_is_read   <= 1'b0;
      r_err       <= 1'b0;
      r_lat_cnt   <= 3'd0;
      r_rdata     <= 32'h0000_0000;
      r_complete  <= 1'b0;
      r_err_out   <= 1'b0;
      r_bram_addr <= '0;
      r_bram_en   <= 1'b0;
      r_bram_we   <= 4'h0;
      r_bram_din  <= 32'h0000_0000;
      r_rd_count  <= 16'h0000;
      r_wr_count  <= 16'h0000;
    end else begin
      // Pulses and strobes fall back to 0 unless a state raises them.
      r_complete <= 1'b0;
      r_err_out  <= 1'b0;
      r_bram_en  <= 1'b0;
      r_bram_we  <= 4'h0;
      case (r_state)
        ST_IDLE: begin
          // While the completion pulse is on the wire the requester may still
          // be holding the old start level, so it is not taken as new work.
          if (!r_complete && aes_start_read) begin
            r_is_read <= 1'b1;
            if (w_rd_misaligned) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_err       <= 1'b0;
              r_bram_en   <= 1'b1;
              r_bram_addr <= aes_bram_addr[ADDR_WIDTH-1:0];
              r_state     <= ST_RD_ISSUE;
            end
          end else if (!r_complete && aes_start_write) begin
            r_is_read <= 1'b0;
            if (w_wr_misaligned) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_err       <= 1'b0;
              r_bram_en   <= 1'b1;
              r_bram_we   <= 4'hF;
              r_bram_addr <= aes_bram_write_addr[ADDR_WIDTH-1:0];
              r_bram_din  <= aes_bram_write_data;
              r_state     <= ST_WR_ISSUE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_ISSUE: begin
          // The enable cycle is ending; start counting the BRAM pipeline.
          r_lat_cnt <= LAT_LOAD;
          r_state   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (r_lat_cnt <= 3'd1) begin
            r_rdata <= bram_dout;
            r_state <= ST_DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
            r_state   <= ST_RD_WAIT;
          end
        end
        ST_WR_ISSUE: begin
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_complete <= 1'b1;
          r_err_out  <= r_err;
          // Only transactions that reached the BRAM are counted.
          if (!r_err && r_is_read) begin
            r_rd_count <= r_rd_count + 16'd1;
          end else if (!r_err) begin
            r_wr_count <= r_wr_count + 16'd1;
          end else begin
            r_rd_count <= r_rd_count;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign aes_bram_read_data = r_rdata;
  assign bram_complete      = r_complete;
  assign bram_err           = r_err_out;
  assign bram_addr          = r_bram_addr;
  assign bram_en            = r_bram_en;
  assign bram_we            = r_bram_we;
  assign bram_din           = r_bram_din;
  assign rd_count           = r_rd_count;
  assign wr_count           = r_wr_count;

endmodule

// File: tb/tb_aes_bram_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_bram_port_ctrl
//
// Directed bench for aes_bram_port_ctrl with READ_LATENCY=2. A small BRAM
// model with a two-stage read pipeline sits on Port B. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_aes_bram_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aes_start_read;
  logic        aes_start_write;
  logic [31:0] aes_bram_addr;
  logic [31:0] aes_bram_write_addr;
  logic [31:0] aes_bram_write_data;
  logic [31:0] aes_bram_read_data;
  logic        bram_complete;
  logic        bram_err;
  logic [31:0] bram_addr;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int en_cnt   = 0;
  int comp_cnt = 0;
  logic [31:0] last_en_addr = 32'h0;
  logic [3:0]  last_en_we   = 4'h0;
  logic [31:0] last_en_din  = 32'h0;

  aes_bram_port_ctrl #(.READ_LATENCY(2), .ADDR_WIDTH(32)) dut (
    .aes_clk             (clk),
    .aes_rst_n           (rst_n),
    .aes_start_read      (aes_start_read),
    .aes_start_write     (aes_start_write),
    .aes_bram_addr       (aes_bram_addr),
    .aes_bram_write_addr (aes_bram_write_addr),
    .aes_bram_write_data (aes_bram_write_data),
    .aes_bram_read_data  (aes_bram_read_data),
    .bram_complete       (bram_complete),
    .bram_err            (bram_err),
    .bram_addr           (bram_addr),
    .bram_en             (bram_en),
    .bram_we             (bram_we),
    .bram_din            (bram_din),
    .bram_dout           (bram_dout),
    .rd_count            (rd_count),
    .wr_count            (wr_count)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: preloaded on its first edge, writes on en&we, 2-stage read.
  logic [31:0] mem [0:15];
  logic [31:0] rd_pipe0 = 32'h0;
  logic [31:0] rd_pipe1 = 32'h0;
  logic        mem_ready = 1'b0;

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      0:       init_word = 32'h1111_0000;
      1:       init_word = 32'h2222_0004;
      2:       init_word = 32'h3333_0008;
      3:       init_word = 32'h4444_000C;
      4:       init_word = 32'hDEAD_BEEF;
      default: init_word = 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bram_en && bram_we == 4'hF) begin
      mem[bram_addr[5:2]] <= bram_din;
    end
    rd_pipe0 <= (bram_en && bram_we == 4'h0) ? mem[bram_addr[5:2]] : 32'h0;
    rd_pipe1 <= rd_pipe0;
  end
  assign bram_dout = rd_pipe1;

  // Bus monitor on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (bram_en) begin
      en_cnt       <= en_cnt + 1;
      last_en_addr <= bram_addr;
      last_en_we   <= bram_we;
      last_en_din  <= bram_din;
    end
    if (bram_complete) comp_cnt <= comp_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Waits (bounded) for a completion pulse, sampling on falling edges.
  task automatic wait_complete(input int c0, output int lat, output logic err);
    logic seen;
    seen = 1'b0;
    lat  = -1;
    err  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bram_complete) begin
        seen = 1'b1;
        lat  = cyc - c0 + 1;
        err  = bram_err;
      end
    end
  endtask

  // Raises the request on a falling edge, waits for completion, drops it.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] ra,
                       input logic [31:0] wa, input logic [31:0] wd,
                       output int lat, output logic err);
    int c0;
    @(negedge clk);
    aes_start_read      = rd;
    aes_start_write     = wr;
    aes_bram_addr       = ra;
    aes_bram_write_addr = wa;
    aes_bram_write_data = wd;
    @(posedge clk);
    #1 c0 = cyc;
    wait_complete(c0, lat, err);
    aes_start_read  = 1'b0;
    aes_start_write = 1'b0;
  endtask

  int          lat;
  logic        err;
  int          en0;
  int          comp0;
  int          c0;
  logic [31:0] exp_b2b [0:3];

  initial begin
    rst_n               = 1'b0;
    aes_start_read      = 1'b0;
    aes_start_write     = 1'b0;
    aes_bram_addr       = 32'h0;
    aes_bram_write_addr = 32'h0;
    aes_bram_write_data = 32'h0;
    exp_b2b[0] = 32'h1111_0000;
    exp_b2b[1] = 32'h2222_0004;
    exp_b2b[2] = 32'h3333_0008;
    exp_b2b[3] = 32'h4444_000C;
    repeat (3) @(negedge clk);
    check_eq("rst_rdata", aes_bram_read_data, 32'h0);
    check_eq("rst_outs", {27'h0, bram_complete, bram_err, bram_en, (bram_we != 4'h0), (bram_din != 32'h0)}, 32'h0);
    check_eq("rst_counts", {rd_count, wr_count}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single aligned read at 0x10
    en0 = en_cnt;
    issue(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, lat, err);
    check_eq("rd1_lat", 32'(lat), 32'd5);
    check_eq("rd1_data", aes_bram_read_data, 32'hDEAD_BEEF);
    check_eq("rd1_err", {31'h0, err}, 32'h0);
    check_eq("rd1_count", {16'h0, rd_count}, 32'd1);
    check_eq("rd1_en_cycles", 32'(en_cnt - en0), 32'd1);
    check_eq("rd1_en_addr", last_en_addr, 32'h10);
    check_eq("rd1_en_we", {28'h0, last_en_we}, 32'h0);

    // Write 0xCAFEF00D to 0x20, then read it back
    en0 = en_cnt;
    issue(1'b0, 1'b1, 32'h0, 32'h20, 32'hCAFE_F00D, lat, err);
    check_eq("wr1_lat", 32'(lat), 32'd3);
    check_eq("wr1_count", {16'h0, wr_count}, 32'd1);
    check_eq("wr1_en_cycles", 32'(en_cnt - en0), 32'd1);
    check_eq("wr1_en_we", {28'h0, last_en_we}, 32'hF);
    check_eq("wr1_en_addr", last_en_addr, 32'h20);
    check_eq("wr1_en_din", last_en_din, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, lat, err);
    check_eq("wr1_readback", aes_bram_read_data, 32'hCAFE_F00D);
    check_eq("rd2_count", {16'h0, rd_count}, 32'd2);

    // Four back-to-back reads, start re-raised one cycle after each complete
    en0 = en_cnt;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, 32'(i * 4), 32'h0, 32'h0, lat, err);
      check_eq("b2b_data", aes_bram_read_data, exp_b2b[i]);
      check_eq("b2b_lat", 32'(lat), 32'd5);
    end
    check_eq("b2b_count", {16'h0, rd_count}, 32'd6);
    check_eq("b2b_en_cycles", 32'(en_cnt - en0), 32'd4);

    // Read and write together: read first, write once read drops
    @(negedge clk);
    aes_start_read      = 1'b1;
    aes_start_write     = 1'b1;
    aes_bram_addr       = 32'h0;
    aes_bram_write_addr = 32'h24;
    aes_bram_write_data = 32'h1234_5678;
    @(posedge clk);
    #1 c0 = cyc;
    wait_complete(c0, lat, err);
    aes_start_read = 1'b0;
    check_eq("both_first_lat", 32'(lat), 32'd5);
    check_eq("both_first_data", aes_bram_read_data, 32'h1111_0000);
    check_eq("both_first_err", {31'h0, err}, 32'h0);
    check_eq("both_first_counts", {rd_count, wr_count}, {16'd7, 16'd1});
    wait_complete(cyc, lat, err);
    aes_start_write = 1'b0;
    check_eq("both_second_err", {31'h0, err}, 32'h0);
    check_eq("both_second_counts", {rd_count, wr_count}, {16'd7, 16'd2});
    check_eq("both_mem", mem[9], 32'h1234_5678);

    // Misaligned read and write
    en0 = en_cnt;
    issue(1'b1, 1'b0, 32'h13, 32'h0, 32'h0, lat, err);
    check_eq("mis_rd_lat", 32'(lat), 32'd2);
    check_eq("mis_rd_err", {31'h0, err}, 32'h1);
    check_eq("mis_rd_count", {16'h0, rd_count}, 32'd7);
    check_eq("mis_rd_data", aes_bram_read_data, 32'h1111_0000);
    issue(1'b0, 1'b1, 32'h0, 32'h22, 32'hFFFF_FFFF, lat, err);
    check_eq("mis_wr_err", {31'h0, err}, 32'h1);
    check_eq("mis_wr_count", {16'h0, wr_count}, 32'd2);
    check_eq("mis_en_cycles", 32'(en_cnt - en0), 32'd0);
    @(negedge clk);
    check_eq("err_pulse_width", {31'h0, bram_err}, 32'h0);

    // Reset while in RD_WAIT
    @(negedge clk);
    aes_start_read = 1'b1;
    aes_bram_addr  = 32'h10;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    comp0 = comp_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("arst_counts", {rd_count, wr_count}, 32'h0);
    check_eq("arst_addr", bram_addr, 32'h0);
    check_eq("arst_rdata", aes_bram_read_data, 32'h0);
    check_eq("arst_strobes", {30'h0, bram_en, bram_complete}, 32'h0);
    aes_start_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("arst_no_complete", 32'(comp_cnt - comp0), 32'd0);
    en0 = en_cnt;
    issue(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, lat, err);
    check_eq("post_rst_lat", 32'(lat), 32'd5);
    check_eq("post_rst_data", aes_bram_read_data, 32'hDEAD_BEEF);
    check_eq("post_rst_count", {16'h0, rd_count}, 32'd1);
    check_eq("post_rst_en_cycles", 32'(en_cnt - en0), 32'd1);

    // Read counter wrap
    @(negedge clk);
    force dut.r_rd_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_rd_count;
    @(negedge clk);
    check_eq("wrap_preset", {16'h0, rd_count}, 32'h0000_FFFF);
    issue(1'b1, 1'b0, 32'h4, 32'h0, 32'h0, lat, err);
    check_eq("wrap_count", {16'h0, rd_count}, 32'h0);
    check_eq("wrap_data", aes_bram_read_data, 32'h2222_0004);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
